if_id_queue: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry in-order FIFO carrying {instr, pc, pc_plus_4} from fetch to decode.
- Uses valid/ready handshakes on both sides in place of a bare stall/flush pair, so fetch can run ahead of a stalled decode.
- Supports a synchronous flush for branch/jump redirects.
- When the queue is empty it presents a NOP bubble to decode.

---
 rtl/if_id_queue.sv | 126 ++++++++++++
 tb/tb_if_id_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// In-order IF/ID queue: DEPTH-entry FIFO of {instr, pc, pc_plus_4} with valid/ready on both sides.
// Optional same-cycle empty-queue forwarding is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid_f_i,
  output logic                          push_ready_f_o,
  input  logic [INSTR_WIDTH-1:0]        instr_f_i,
  input  logic [DATA_WIDTH-1:0]         pc_f_i,
  input  logic [DATA_WIDTH-1:0]         pc_plus_4_f_i,
  input  logic                          flush_d_i,
  output logic                          pop_valid_id_o,
  input  logic                          pop_ready_id_i,
  output logic [INSTR_WIDTH-1:0]        instr_id_o,
  output logic [DATA_WIDTH-1:0]         pc_id_o,
  output logic [DATA_WIDTH-1:0]         pc_plus_4_id_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0]  pcp4_mem_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty_s, full_s, bypass_s, push_fire_s, pop_fire_s, do_write_s, do_read_s;

  assign empty_s        = (count_q == CNT_W'(0));
  assign full_s         = (count_q == CNT_W'(DEPTH));
  assign push_ready_f_o = !full_s;
  assign count_o        = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass_s = empty_s && push_valid_f_i && !flush_d_i;
`else
  assign bypass_s = 1'b0;
`endif

  assign pop_valid_id_o = !empty_s || bypass_s;
  assign push_fire_s    = push_valid_f_i && push_ready_f_o;
  assign pop_fire_s     = pop_valid_id_o && pop_ready_id_i;
  // A forwarded entry that decode takes immediately is never stored.
  assign do_write_s     = push_fire_s && !(bypass_s && pop_ready_id_i);
  assign do_read_s      = pop_fire_s && !empty_s;

  // Head presentation: stored entry, forwarded entry, or NOP bubble.
  always_comb begin
    instr_id_o     = NOP_INSTR;
    pc_id_o        = {DATA_WIDTH{1'b0}};
    pc_plus_4_id_o = {DATA_WIDTH{1'b0}};
    if (!empty_s) begin
      instr_id_o     = instr_mem_q[rd_ptr_q];
      pc_id_o        = pc_mem_q[rd_ptr_q];
      pc_plus_4_id_o = pcp4_mem_q[rd_ptr_q];
    end else if (bypass_s) begin
      instr_id_o     = instr_f_i;
      pc_id_o        = pc_f_i;
      pc_plus_4_id_o = pc_plus_4_f_i;
    end else begin
      instr_id_o     = NOP_INSTR;
      pc_id_o        = {DATA_WIDTH{1'b0}};
      pc_plus_4_id_o = {DATA_WIDTH{1'b0}};
    end
  end

  // Pointer and occupancy next-state; flush overrides any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_d_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_write_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_read_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_write_s, do_read_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_write_s && !flush_d_i) begin
      instr_mem_q[wr_ptr_q] <= instr_f_i;
      pc_mem_q[wr_ptr_q]    <= pc_f_i;
      pcp4_mem_q[wr_ptr_q]  <= pc_plus_4_f_i;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid_f_i;
  logic        push_ready_f_o;
  logic [31:0] instr_f_i;
  logic [31:0] pc_f_i;
  logic [31:0] pc_plus_4_f_i;
  logic        flush_d_i;
  logic        pop_valid_id_o;
  logic        pop_ready_id_i;
  logic [31:0] instr_id_o;
  logic [31:0] pc_id_o;
  logic [31:0] pc_plus_4_id_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  if_id_queue dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid_f_i (push_valid_f_i),
    .push_ready_f_o (push_ready_f_o),
    .instr_f_i      (instr_f_i),
    .pc_f_i         (pc_f_i),
    .pc_plus_4_f_i  (pc_plus_4_f_i),
    .flush_d_i      (flush_d_i),
    .pop_valid_id_o (pop_valid_id_o),
    .pop_ready_id_i (pop_ready_id_i),
    .instr_id_o     (instr_id_o),
    .pc_id_o        (pc_id_o),
    .pc_plus_4_id_o (pc_plus_4_id_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    push_valid_f_i = v;
    instr_f_i      = instr;
    pc_f_i         = pc;
    pc_plus_4_f_i  = pc + 32'd4;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, {29'd0, count_o}, 32'd0);
    chk({tag, "_pvalid"}, {31'd0, pop_valid_id_o}, 32'd0);
    chk({tag, "_instr"}, instr_id_o, 32'h0000_0013);
    chk({tag, "_pc"}, pc_id_o, 32'd0);
    chk({tag, "_pcp4"}, pc_plus_4_id_o, 32'd0);
    chk({tag, "_pready"}, {31'd0, push_ready_f_o}, 32'd1);
  endtask

  initial begin
    int      cnt;
    int      pushed;
    int      popped;
    int      c;
    logic    pr;
    logic [31:0] q[$];

    rst = 1'b1;
    flush_d_i = 1'b0;
    pop_ready_id_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #3;
    chk_reset_outputs("reset");
    #9 rst = 1'b0;
    #2;

    // Three pushes with decode stalled
    drive(1'b1, 32'h0050_0093, 32'h0); cyc();
    drive(1'b1, 32'h0060_0113, 32'h4); cyc();
    drive(1'b1, 32'h0020_81B3, 32'h8); cyc();
    drive(1'b0, 32'd0, 32'd0); #1;
    chk("t1_count", {29'd0, count_o}, 32'd3);
    chk("t1_pvalid", {31'd0, pop_valid_id_o}, 32'd1);
    chk("t1_instr", instr_id_o, 32'h0050_0093);
    chk("t1_pc", pc_id_o, 32'h0);
    chk("t1_pcp4", pc_plus_4_id_o, 32'h4);

    // Fill to DEPTH, then push+pop while full
    drive(1'b1, 32'h0070_0193, 32'hC); cyc();
    drive(1'b1, 32'h0080_0213, 32'h10);
    pop_ready_id_i = 1'b1; #1;
    chk("t2_full_count", {29'd0, count_o}, 32'd4);
    chk("t2_pready", {31'd0, push_ready_f_o}, 32'd0);
    chk("t2_head0", pc_id_o, 32'h0);
    cyc();
    drive(1'b0, 32'd0, 32'd0); #1;
    chk("t2_count_after", {29'd0, count_o}, 32'd3);
    chk("t2_head1", pc_id_o, 32'h4);
    cyc();
    chk("t2_head2", pc_id_o, 32'h8);
    cyc();
    chk("t2_head3", pc_id_o, 32'hC);
    chk("t2_instr3", instr_id_o, 32'h0070_0193);
    cyc();
    chk("t2_empty_count", {29'd0, count_o}, 32'd0);
    chk("t2_empty_pvalid", {31'd0, pop_valid_id_o}, 32'd0);
    chk("t2_empty_instr", instr_id_o, 32'h0000_0013);

    // Simultaneous push and pop at count 2
    pop_ready_id_i = 1'b0;
    drive(1'b1, 32'h1111_0013, 32'h20); cyc();
    drive(1'b1, 32'h2222_0013, 32'h24); cyc();
    drive(1'b1, 32'h3333_0013, 32'h28);
    pop_ready_id_i = 1'b1; cyc();
    drive(1'b0, 32'd0, 32'd0); pop_ready_id_i = 1'b0; #1;
    chk("t3_count", {29'd0, count_o}, 32'd2);
    chk("t3_head", pc_id_o, 32'h24);
    pop_ready_id_i = 1'b1; cyc();
    chk("t3_head_next", pc_id_o, 32'h28);
    cyc();
    pop_ready_id_i = 1'b0;
    chk("t3_drained", {29'd0, count_o}, 32'd0);

    // Flush at count 3 with a same-cycle push
    drive(1'b1, 32'hA000_0013, 32'h30); cyc();
    drive(1'b1, 32'hA100_0013, 32'h34); cyc();
    drive(1'b1, 32'hA200_0013, 32'h38); cyc();
    chk("t4_pre_count", {29'd0, count_o}, 32'd3);
    drive(1'b1, 32'hA300_0013, 32'h3C);
    flush_d_i = 1'b1; cyc();
    flush_d_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0); #1;
    chk("t4_count", {29'd0, count_o}, 32'd0);
    chk("t4_pvalid", {31'd0, pop_valid_id_o}, 32'd0);
    chk("t4_instr", instr_id_o, 32'h0000_0013);
    chk("t4_pc", pc_id_o, 32'd0);
    cyc();
    chk("t4_still_empty", {29'd0, count_o}, 32'd0);

    // Ten pushes with decode ready every other cycle; queue model checks order
    cnt = 0; pushed = 0; popped = 0; c = 0;
    while (popped < 10 && c < 60) begin
      pr = (c % 2) == 1;
      pop_ready_id_i = pr;
      drive(pushed < 10, {8'hB0, 24'(pushed)}, 32'(pushed * 4));
      #1;
      chk("t5_count", {29'd0, count_o}, 32'(cnt));
      chk("t5_pvalid", {31'd0, pop_valid_id_o}, {31'd0, cnt > 0});
      chk("t5_pready", {31'd0, push_ready_f_o}, {31'd0, cnt < 4});
      if (cnt > 0) chk("t5_head", pc_id_o, q[0]);
      if (cnt > 0 && pr) begin
        void'(q.pop_front());
        popped++;
      end
      if (pushed < 10 && cnt < 4) begin
        q.push_back(32'(pushed * 4));
        pushed++;
      end
      cnt = q.size();
      cyc();
      c++;
    end
    chk("t5_popped_total", 32'(popped), 32'd10);
    chk("t5_pushed_total", 32'(pushed), 32'd10);

    // Asynchronous reset mid-stream
    pop_ready_id_i = 1'b0;
    drive(1'b1, 32'hC000_0013, 32'h50); cyc();
    drive(1'b1, 32'hC100_0013, 32'h54); cyc();
    chk("t5_prerst_count", {29'd0, count_o}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    drive(1'b0, 32'd0, 32'd0);
    #2 rst = 1'b0;
    cyc();
    chk("t5_postrst_count", {29'd0, count_o}, 32'd0);

    // Push into empty queue with decode ready
    drive(1'b1, 32'h0050_0093, 32'h40);
    pop_ready_id_i = 1'b1; #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
    chk("t6_pvalid_same", {31'd0, pop_valid_id_o}, 32'd1);
    chk("t6_instr_same", instr_id_o, 32'h0050_0093);
    cyc();
    drive(1'b0, 32'd0, 32'd0); #1;
    chk("t6_count", {29'd0, count_o}, 32'd0);
    chk("t6_pvalid_next", {31'd0, pop_valid_id_o}, 32'd0);
`else
    chk("t6_pvalid_same", {31'd0, pop_valid_id_o}, 32'd0);
    chk("t6_instr_same", instr_id_o, 32'h0000_0013);
    cyc();
    drive(1'b0, 32'd0, 32'd0); #1;
    chk("t6_count", {29'd0, count_o}, 32'd1);
    chk("t6_pvalid_next", {31'd0, pop_valid_id_o}, 32'd1);
    chk("t6_instr_next", instr_id_o, 32'h0050_0093);
    chk("t6_pc_next", pc_id_o, 32'h40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
